mux_8x1_arbiter: RTL and testbench

- Round-robin arbiter and sequencer for the shared 8:1 selection mux in the sale terminal datapath.
- Eight requesters (keypad, price lookup, display, printer, etc.) compete for the single mux output line.
- The block grants one requester at a time and drives the mux select and enable.
- Grants are bounded: released by the owner or by a hold timeout.
- A break-before-make gap cycle separates consecutive grants.

---
 rtl/mux_8x1_arbiter.sv | 100 ++++++++++
 tb/tb_mux_8x1_arbiter.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/mux_8x1_arbiter.sv
// Round-robin arbiter for the shared 8:1 mux: one grantee at a time, bounded hold,
// and a one-cycle break-before-make gap between grants.
module mux_8x1_arbiter #(
    parameter logic [7:0] MAX_HOLD   = 8'd255,
    parameter bit         TIMEOUT_EN = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] req,
    input  logic       done,
    output logic [2:0] sel,
    output logic       mux_en,
    output logic [7:0] gnt,
    output logic       busy,
    output logic       timeout
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GRANT = 2'd1;
    localparam logic [1:0] GAP   = 2'd2;

    logic [1:0] state;
    logic [2:0] last;
    logic [7:0] cnt;
    logic [2:0] win;
    logic [2:0] idx;
    logic       found;
    logic       rel;
    logic       tmo;

    // Search starts just past the previous winner so every requester gets a turn.
    always_comb begin
        win   = last;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < 8; k++) begin
            idx = last + 3'(k + 1);
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    // A voluntary release always wins over a coincident timeout.
    always_comb begin
        rel = done || !req[sel];
        tmo = TIMEOUT_EN && (cnt == MAX_HOLD - 8'd1) && !rel;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            last    <= 3'd7;
            cnt     <= 8'd0;
            sel     <= 3'd0;
            mux_en  <= 1'b0;
            gnt     <= 8'd0;
            busy    <= 1'b0;
            timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    timeout <= 1'b0;
                    busy    <= 1'b0;
                    if (|req) begin
                        state  <= GRANT;
                        sel    <= win;
                        gnt    <= 8'(8'b1 << win);
                        mux_en <= 1'b1;
                        busy   <= 1'b1;
                        last   <= win;
                        cnt    <= 8'd0;
                    end
                end
                GRANT: begin
                    if (rel || tmo) begin
                        state   <= GAP;
                        mux_en  <= 1'b0;
                        gnt     <= 8'd0;
                        timeout <= tmo;
                    end else if (cnt != 8'hFF) begin
                        cnt <= cnt + 8'd1;
                    end
                end
                GAP: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    timeout <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    mux_en  <= 1'b0;
                    gnt     <= 8'd0;
                    busy    <= 1'b0;
                    timeout <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mux_8x1_arbiter.sv
// Bench for mux_8x1_arbiter: directed vectors with literal expectations, plus a
// cycle-level reference model compared against the outputs on every cycle.
module tb_mux_8x1_arbiter;
    localparam int MH = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] req;
    logic       done;
    logic [2:0] sel;
    logic       mux_en;
    logic [7:0] gnt;
    logic       busy;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    mux_8x1_arbiter #(.MAX_HOLD(8'(MH)), .TIMEOUT_EN(1'b1)) dut (
        .clk(clk), .reset(reset), .req(req), .done(done), .sel(sel),
        .mux_en(mux_en), .gnt(gnt), .busy(busy), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Reference model: phase 0=idle, 1=granted, 2=gap; age counts grant cycles so far.
    int ph = 0, m_last = 7, age = 0, m_sel = 0, m_to = 0;
    bit model_ok = 0;
    always @(posedge clk) begin
        if (reset) begin
            ph = 0; m_last = 7; age = 0; m_sel = 0; m_to = 0; model_ok = 1;
        end else if (ph == 0) begin
            m_to = 0;
            if (req != 0) begin
                int w;
                bit f;
                w = 0; f = 0;
                for (int k = 1; k <= 8; k++)
                    if (!f && req[(m_last + k) % 8]) begin w = (m_last + k) % 8; f = 1; end
                ph = 1; m_sel = w; m_last = w; age = 1;
            end
        end else if (ph == 1) begin
            bit voluntary;
            voluntary = done || !req[m_sel];
            if (voluntary) begin ph = 2; m_to = 0; end
            else if (age == MH) begin ph = 2; m_to = 1; end
            else age++;
        end else begin
            ph = 0; m_to = 0;
        end
    end

    logic prev_to = 1'b0;
    always @(negedge clk) begin
        if (model_ok) begin
            chk("m_sel", 32'(sel), 32'(m_sel));
            chk("m_gnt", 32'(gnt), (ph == 1) ? 32'(1 << m_sel) : 32'd0);
            chk("m_mux_en", 32'(mux_en), 32'(ph == 1));
            chk("m_busy", 32'(busy), 32'(ph != 0));
            chk("m_timeout", 32'(timeout), 32'(m_to));
            chk("inv_onehot", 32'($countones(gnt) <= 1), 32'd1);
            chk("inv_en_gnt", 32'((gnt != 0) == mux_en), 32'd1);
            chk("inv_gnt_sel", 32'(gnt == 8'd0 || gnt == 8'(8'b1 << sel)), 32'd1);
            chk("inv_to_pulse", 32'(timeout && prev_to), 32'd0);
            prev_to = timeout;
        end
    end

    initial begin
        int n;
        reset = 1'b1; req = 8'h00; done = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_sel", 32'(sel), 0); chk("rst_gnt", 32'(gnt), 0);
        chk("rst_mux_en", 32'(mux_en), 0); chk("rst_busy", 32'(busy), 0);
        chk("rst_timeout", 32'(timeout), 0);

        // single requester: grant, gap, idle, re-grant
        reset = 1'b0; req = 8'h01;
        @(negedge clk);
        chk("t1_gnt", 32'(gnt), 32'h01); chk("t1_sel", 32'(sel), 0);
        chk("t1_mux_en", 32'(mux_en), 1); chk("t1_busy", 32'(busy), 1);
        done = 1'b1;
        @(negedge clk); done = 1'b0;
        chk("t1_gap_en", 32'(mux_en), 0); chk("t1_gap_busy", 32'(busy), 1);
        chk("t1_gap_gnt", 32'(gnt), 0);
        @(negedge clk);
        chk("t1_idle_busy", 32'(busy), 0);
        @(negedge clk);
        chk("t1_regrant", 32'(gnt), 32'h01);

        // all requesting: rotation 0..7 then 0, each grant released at once
        reset = 1'b1; req = 8'h00;
        @(negedge clk); reset = 1'b0; req = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            chk("rr_gnt", 32'(gnt), 32'(1 << (k % 8)));
            chk("rr_sel", 32'(sel), 32'(k % 8));
            done = 1'b1;
            @(negedge clk); done = 1'b0;
            chk("rr_gap_busy", 32'(busy), 1); chk("rr_gap_gnt", 32'(gnt), 0);
            @(negedge clk);
            chk("rr_idle_busy", 32'(busy), 0);
        end

        // wrap search: after grant 2, 3..7 empty so 0 wins
        reset = 1'b1; req = 8'h00;
        @(negedge clk); reset = 1'b0; req = 8'h04;
        @(negedge clk);
        chk("wrap_first", 32'(gnt), 32'h04);
        done = 1'b1; req = 8'h03;
        @(negedge clk); done = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("wrap_gnt", 32'(gnt), 32'h01); chk("wrap_sel", 32'(sel), 0);

        // hold timeout: grant lasts exactly MH cycles, one-cycle timeout pulse
        reset = 1'b1; req = 8'h00;
        @(negedge clk); reset = 1'b0; req = 8'h10;
        @(negedge clk);
        n = 0;
        for (int i = 0; i < 20 && gnt == 8'h10; i++) begin
            n++;
            @(negedge clk);
        end
        chk("to_len", 32'(n), 32'(MH));
        chk("to_pulse", 32'(timeout), 1); chk("to_gap_busy", 32'(busy), 1);
        @(negedge clk);
        chk("to_clear", 32'(timeout), 0);
        @(negedge clk);
        chk("to_regrant", 32'(gnt), 32'h10);

        // done coincident with the timeout cycle is a normal release
        repeat (3) @(negedge clk);
        chk("d4_still", 32'(gnt), 32'h10);
        done = 1'b1;
        @(negedge clk); done = 1'b0;
        chk("d4_timeout", 32'(timeout), 0); chk("d4_gnt", 32'(gnt), 0);
        @(negedge clk);
        @(negedge clk);
        chk("wd_regrant", 32'(gnt), 32'h10);
        repeat (3) @(negedge clk);
        req = 8'h00;
        @(negedge clk);
        chk("wd_timeout", 32'(timeout), 0); chk("wd_gnt", 32'(gnt), 0);
        chk("wd_busy", 32'(busy), 1);

        // reset mid-grant restores the pointer
        @(negedge clk); req = 8'h20;
        @(negedge clk);
        @(negedge clk);
        chk("mr_gnt", 32'(gnt), 32'h20); chk("mr_sel", 32'(sel), 5);
        reset = 1'b1;
        @(negedge clk);
        chk("mr_rst_gnt", 32'(gnt), 0); chk("mr_rst_en", 32'(mux_en), 0);
        chk("mr_rst_sel", 32'(sel), 0); chk("mr_rst_busy", 32'(busy), 0);
        reset = 1'b0; req = 8'h81;
        @(negedge clk);
        chk("mr_gnt0", 32'(gnt), 32'h01); chk("mr_sel0", 32'(sel), 0);

        req = 8'h00;
        repeat (4) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
